ub_sram_dp: RTL and testbench



---
 rtl/ub_pkg.sv | 47 ++++
 rtl/ub_sram_dp_if.sv | 37 +++
 rtl/ub_mem_core.sv | 40 ++++
 rtl/ub_sram_dp.sv | 210 +++++++++++++++++++++
 tb/tb_ub_sram_dp.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ub_pkg.sv
// Purpose: shared types, constants and helpers for the unified buffer.
// Latency: n/a (types, constants and combinational helper only).
// Backpressure: n/a.
package ub_pkg;

    // Sweep/idle controller states.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ub_state_t;

    // Read latencies the output pipeline can be built for.
    localparam int UB_RD_LAT_MIN = 1;
    localparam int UB_RD_LAT_MAX = 2;

    // Upper bounds for the generic lane-merge helper below.
    localparam int UB_MAX_W     = 1024;
    localparam int UB_MAX_LANES = 128;

    function automatic bit ub_rd_lat_legal(input int rd_lat);
        return (rd_lat >= UB_RD_LAT_MIN) && (rd_lat <= UB_RD_LAT_MAX);
    endfunction

    // Per-lane merge: lane i comes from new_word when mask[i] is set,
    // otherwise from old_word. Callers zero-extend into the max width and
    // truncate the result back to their own word width.
    function automatic logic [UB_MAX_W-1:0] ub_lane_merge(
        input logic [UB_MAX_W-1:0]     old_word,
        input logic [UB_MAX_W-1:0]     new_word,
        input logic [UB_MAX_LANES-1:0] mask,
        input int                      lane_w
    );
        logic [UB_MAX_W-1:0] res;
        int                  li;
        res = old_word;
        for (int b = 0; b < UB_MAX_W; b++) begin
            li = b / lane_w;
            if (li < UB_MAX_LANES) begin
                if (mask[li[6:0]]) begin
                    res[b[9:0]] = new_word[b[9:0]];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ub_sram_dp_if.sv
// Purpose: write + read request/response bundle of the unified buffer.
// Latency: n/a (wiring only).
// Backpressure: wr_ready / rd_ready driven by the buffer (low while clearing).
// Ports (master = requester side, slave = buffer side):
//   wr_valid/wr_ready/wr_addr/wr_mask/wr_data  write request with lane mask
//   rd_valid/rd_ready/rd_addr                  read request
//   rd_data/rd_data_valid                      read response, one-cycle strobe
interface ub_sram_dp_if #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 20,
    parameter int LANE_W = 8
) ();
    localparam int W = LANES * LANE_W;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANES-1:0]  wr_mask;
    logic [W-1:0]      wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              rd_data_valid;

    modport master (
        output wr_valid, wr_addr, wr_mask, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_data, rd_data_valid
    );

    modport slave (
        input  wr_valid, wr_addr, wr_mask, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_data, rd_data_valid
    );

endinterface

// File: rtl/ub_mem_core.sv
// Purpose: simple dual-port storage array, per-lane write enable, no reset.
// Latency: read data registered, valid one cycle after i_re; old data on same-address write.
// Backpressure: none, accepts one write and one read every cycle.
// Ports: clk; i_we/i_waddr/i_wmask/i_wdata write port; i_re/i_raddr read port;
//        o_rdata registered read word (holds while i_re is low).
module ub_mem_core #(
    parameter int ADDR_W = 10,
    parameter int LANES  = 20,
    parameter int LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_waddr,
    input  logic [LANES-1:0]        i_wmask,
    input  logic [LANES*LANE_W-1:0] i_wdata,
    input  logic                    i_re,
    input  logic [ADDR_W-1:0]       i_raddr,
    output logic [LANES*LANE_W-1:0] o_rdata
);
    localparam int W     = LANES * LANE_W;
    localparam int DEPTH = 1 << ADDR_W;

    (* ram_style = "block" *) logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // No reset here so the array and its output register map onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_we && i_wmask[i]) begin
                r_mem[i_waddr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ub_sram_dp.sv
// Purpose: dual-port unified buffer with zero-fill sweep and write-first collision merge.
// Latency: read accepted at edge N strobes rd_data_valid after edge N+RD_LAT (RD_LAT 1 or 2).
// Backpressure: wr_ready = rd_ready = !busy; both ports accept one request per cycle otherwise.
// Ports: clk, rst_n (async active-low); init_req starts a zero sweep from IDLE;
//        busy high while sweeping; bus = write/read ports (ub_sram_dp_if.slave).
module ub_sram_dp
    import ub_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LANES  = 20,
    parameter int LANE_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    output logic        busy,
    ub_sram_dp_if.slave bus
);
    localparam int W = LANES * LANE_W;

    if (!ub_rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("ub_sram_dp: RD_LAT must be 1 or 2");
    end
    if ((W > UB_MAX_W) || (LANES > UB_MAX_LANES)) begin : g_bad_width
        $error("ub_sram_dp: word wider than the lane-merge helper supports");
    end

    // ------------------------------------------------------------------
    // Sweep controller
    // ------------------------------------------------------------------
    ub_state_t         r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Last address is written on this edge; leave together with it.
                    if (&r_cnt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (init_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign bus.wr_ready = !r_busy;
    assign bus.rd_ready = !r_busy;

    // ------------------------------------------------------------------
    // Handshakes, write mux and collision detect
    // ------------------------------------------------------------------
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_col;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [LANES-1:0]  w_mem_wmask;
    logic [W-1:0]      w_mem_wdata;
    logic [W-1:0]      w_core_rdata;

    assign w_wr_acc = bus.wr_valid && !r_busy;
    assign w_rd_acc = bus.rd_valid && !r_busy;
    assign w_col    = w_wr_acc && w_rd_acc && (bus.wr_addr == bus.rd_addr);

    // The sweep owns the write port while busy; users are held off by ready.
    assign w_mem_we    = r_busy || w_wr_acc;
    assign w_mem_waddr = r_busy ? r_cnt : bus.wr_addr;
    assign w_mem_wmask = r_busy ? '1    : bus.wr_mask;
    assign w_mem_wdata = r_busy ? '0    : bus.wr_data;

    ub_mem_core #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wmask (w_mem_wmask),
        .i_wdata (w_mem_wdata),
        .i_re    (w_rd_acc),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_core_rdata)
    );

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 runs alongside the array's read register.
    // The write side of a collision travels with it so the merge can be
    // done once, at the output.
    // ------------------------------------------------------------------
    logic             r_s1_vld;
    logic             r_s1_col;
    logic [LANES-1:0] r_s1_mask;
    logic [W-1:0]     r_s1_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_col <= 1'b0;
        end else begin
            r_s1_vld <= w_rd_acc;
            r_s1_col <= w_col;
        end
    end

    // Only consumed when the collision flag is set, so captured only then.
    always_ff @(posedge clk) begin
        if (w_col) begin
            r_s1_mask  <= bus.wr_mask;
            r_s1_wdata <= bus.wr_data;
        end
    end

    logic             w_fin_vld;
    logic             w_fin_col;
    logic [LANES-1:0] w_fin_mask;
    logic [W-1:0]     w_fin_wdata;
    logic [W-1:0]     w_fin_rdata;

    if (RD_LAT == 2) begin : g_stage2
        logic             r_s2_vld;
        logic             r_s2_col;
        logic [LANES-1:0] r_s2_mask;
        logic [W-1:0]     r_s2_wdata;
        logic [W-1:0]     r_s2_rdata;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_vld <= 1'b0;
                r_s2_col <= 1'b0;
            end else begin
                r_s2_vld <= r_s1_vld;
                r_s2_col <= r_s1_col;
            end
        end

        always_ff @(posedge clk) begin
            if (r_s1_vld) begin
                r_s2_mask  <= r_s1_mask;
                r_s2_wdata <= r_s1_wdata;
                r_s2_rdata <= w_core_rdata;
            end
        end

        assign w_fin_vld   = r_s2_vld;
        assign w_fin_col   = r_s2_col;
        assign w_fin_mask  = r_s2_mask;
        assign w_fin_wdata = r_s2_wdata;
        assign w_fin_rdata = r_s2_rdata;
    end else begin : g_stage1
        assign w_fin_vld   = r_s1_vld;
        assign w_fin_col   = r_s1_col;
        assign w_fin_mask  = r_s1_mask;
        assign w_fin_wdata = r_s1_wdata;
        assign w_fin_rdata = w_core_rdata;
    end

    // Array returns pre-write contents on a same-address collision; lay the
    // written lanes over it here to give write-first behaviour per lane.
    logic [W-1:0] w_rd_word;

    always_comb begin
        w_rd_word = w_fin_rdata;
        if (w_fin_col) begin
            w_rd_word = W'(ub_lane_merge(UB_MAX_W'(w_fin_rdata), UB_MAX_W'(w_fin_wdata),
                                         UB_MAX_LANES'(w_fin_mask), LANE_W));
        end
    end

    logic         r_rd_vld;
    logic [W-1:0] r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= w_fin_vld;
            if (w_fin_vld) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_vld;

endmodule

// File: tb/tb_ub_sram_dp.sv
module tb_ub_sram_dp;
    localparam int ADDR_W = 10;
    localparam int LANES  = 20;
    localparam int LANE_W = 8;
    localparam int W      = LANES * LANE_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_req;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [LANES-1:0]  wr_mask;
    logic [W-1:0]      wr_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy1;
    logic              busy2;

    always #5 clk = ~clk;

    ub_sram_dp_if #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W)) if1 ();
    ub_sram_dp_if #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W)) if2 ();

    assign if1.wr_valid = wr_valid;
    assign if1.wr_addr  = wr_addr;
    assign if1.wr_mask  = wr_mask;
    assign if1.wr_data  = wr_data;
    assign if1.rd_valid = rd_valid;
    assign if1.rd_addr  = rd_addr;
    assign if2.wr_valid = wr_valid;
    assign if2.wr_addr  = wr_addr;
    assign if2.wr_mask  = wr_mask;
    assign if2.wr_data  = wr_data;
    assign if2.rd_valid = rd_valid;
    assign if2.rd_addr  = rd_addr;

    ub_sram_dp #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W), .RD_LAT(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_req (init_req),
        .busy     (busy1),
        .bus      (if1.slave)
    );

    ub_sram_dp #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W), .RD_LAT(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_req (init_req),
        .busy     (busy2),
        .bus      (if2.slave)
    );

    // Reference model: plain memory array, remaining-busy countdown and
    // per-latency queues of expected responses.
    logic [W-1:0] ref_mem [DEPTH];
    int           clear_left;
    int           cyc;
    exp_t         q1[$];
    exp_t         q2[$];
    logic [W-1:0] last1;
    logic [W-1:0] last2;
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {LANES{b}};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        chkb("busy1", busy1, clear_left > 0);
        chkb("busy2", busy2, clear_left > 0);
        chkb("wr_ready1", if1.wr_ready, clear_left == 0);
        chkb("rd_ready2", if2.rd_ready, clear_left == 0);
        ev = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev = 1'b1;
            last1 = q1[0].data;
            void'(q1.pop_front());
        end
        chkb("rd_vld1", if1.rd_data_valid, ev);
        chk("rd_data1", if1.rd_data, last1);
        ev = 1'b0;
        if (q2.size() > 0 && q2[0].due == cyc) begin
            ev = 1'b1;
            last2 = q2[0].data;
            void'(q2.pop_front());
        end
        chkb("rd_vld2", if2.rd_data_valid, ev);
        chk("rd_data2", if2.rd_data, last2);
    endtask

    // One clock edge: update the model with what was presented, then check.
    task automatic tick();
        logic [W-1:0] rdat;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            clear_left = DEPTH;
            q1.delete();
            q2.delete();
            last1 = '0;
            last2 = '0;
            foreach (ref_mem[a]) ref_mem[a] = '0;
        end else begin
            if (wr_valid && clear_left == 0) begin
                for (int i = 0; i < LANES; i++)
                    if (wr_mask[i]) ref_mem[wr_addr][i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
            end
            if (rd_valid && clear_left == 0) begin
                rdat = ref_mem[rd_addr];
                q1.push_back('{due: cyc + 1, data: rdat});
                q2.push_back('{due: cyc + 2, data: rdat});
            end
            if (clear_left > 0) begin
                clear_left--;
            end else if (init_req) begin
                clear_left = DEPTH;
                foreach (ref_mem[a]) ref_mem[a] = '0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic set_wr(input int a, input logic [W-1:0] d, input logic [LANES-1:0] m);
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(a);
        wr_data  = d;
        wr_mask  = m;
    endtask

    task automatic set_rd(input int a);
        rd_valid = 1'b1;
        rd_addr  = ADDR_W'(a);
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkb("rst_busy1", busy1, 1'b1);
        chkb("rst_busy2", busy2, 1'b1);
        chkb("rst_wr_ready1", if1.wr_ready, 1'b0);
        chkb("rst_rd_ready2", if2.rd_ready, 1'b0);
        chkb("rst_vld1", if1.rd_data_valid, 1'b0);
        chkb("rst_vld2", if2.rd_data_valid, 1'b0);
        chk("rst_data1", if1.rd_data, '0);
        chk("rst_data2", if2.rd_data, '0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [W-1:0] exp_w;

    initial begin
        rst_n    = 1'b0;
        init_req = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_mask  = '0;
        wr_data  = '0;
        cyc      = 0;
        clear_left = DEPTH;
        last1    = '0;
        last2    = '0;
        set_rd(5);

        // Reset values, then the power-up sweep with a read held pending.
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DEPTH) tick();
        tick();
        tick();
        chkb("first_rd_vld1", if1.rd_data_valid, 1'b1);
        chk("first_rd_dat1", if1.rd_data, '0);
        tick();
        chkb("first_rd_vld2", if2.rd_data_valid, 1'b1);
        chk("first_rd_dat2", if2.rd_data, '0);
        idle();
        tick();
        tick();

        // Write then read the next cycle.
        set_wr(3, rep(8'hA5), '1);
        tick();
        idle();
        set_rd(3);
        tick();
        idle();
        tick();
        tick();
        chk("a5_dut1", if1.rd_data, rep(8'hA5));
        chk("a5_dut2", if2.rd_data, rep(8'hA5));

        // Same-address collision with a partial mask.
        set_wr(3, rep(8'h11), '1);
        tick();
        set_wr(3, rep(8'hFF), 20'h00005);
        set_rd(3);
        tick();
        idle();
        tick();
        tick();
        exp_w = rep(8'h11);
        exp_w[7:0]   = 8'hFF;
        exp_w[23:16] = 8'hFF;
        chk("collide_dut1", if1.rd_data, exp_w);
        chk("collide_dut2", if2.rd_data, exp_w);

        // Fill 0..15, then stream reads back to back.
        for (int a = 0; a < 16; a++) begin
            set_wr(a, rnd_word(), '1);
            tick();
        end
        idle();
        for (int a = 0; a < 16; a++) begin
            set_rd(a);
            tick();
        end
        idle();
        repeat (3) tick();

        // Mask of zero leaves the word untouched.
        set_wr(2, rep(8'h33), '1);
        tick();
        set_wr(2, rep(8'hFF), '0);
        tick();
        idle();
        set_rd(2);
        tick();
        idle();
        tick();
        tick();
        chk("mask0_dut1", if1.rd_data, rep(8'h33));
        chk("mask0_dut2", if2.rd_data, rep(8'h33));

        // Random traffic over a small address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = ADDR_W'($urandom_range(0, 15));
            wr_mask  = LANES'($urandom());
            wr_data  = rnd_word();
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr  = ADDR_W'($urandom_range(0, 15));
            tick();
        end
        idle();
        repeat (3) tick();

        // Sweep on request; handshakes in the request cycle still complete.
        set_wr(9, rep(8'h77), '1);
        tick();
        set_wr(9, rep(8'h55), 20'h0F0F0);
        set_rd(9);
        init_req = 1'b1;
        tick();
        idle();
        for (int n = 0; n < DEPTH; n++) begin
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr  = ADDR_W'($urandom_range(0, 15));
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = ADDR_W'($urandom_range(0, 15));
            wr_mask  = '1;
            wr_data  = rnd_word();
            tick();
        end
        idle();
        set_rd(9);
        tick();
        idle();
        tick();
        tick();
        chk("swept_dut1", if1.rd_data, '0);
        chk("swept_dut2", if2.rd_data, '0);

        // Reset in the middle of a requested sweep restarts it from scratch.
        set_wr(4, rep(8'h3C), '1);
        tick();
        idle();
        init_req = 1'b1;
        tick();
        idle();
        repeat (200) tick();
        async_reset();
        repeat (DEPTH) tick();

        // Reset with reads in flight drops their strobes.
        set_wr(6, rep(8'h5A), '1);
        tick();
        idle();
        set_rd(6);
        tick();
        idle();
        async_reset();
        repeat (DEPTH) tick();
        for (int n = 0; n < 8; n++) begin
            set_rd($urandom_range(0, DEPTH - 1));
            tick();
        end
        idle();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
